// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one synchronous-read RAM shared by the MEM stage (priority) and a debug/DMA port.
// Define DMEM_ARB_STARVE_EN to build the debug starvation guard; otherwise the CPU has strict priority.
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RSP,
    ST_DBG_RSP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_cpu_elig;
  logic   w_cpu_win;
  logic   w_dbg_win;
  logic   w_force;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..15");
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] r_starve_cnt;

  // Counts consecutive denied debug cycles; a held-off debug request wins once it reaches the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (dbg_req && !w_dbg_win) begin
      if (r_starve_cnt != STARVE_LIM) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  assign w_force = (r_starve_cnt == STARVE_LIM);
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue decisions are qualified with reset_n so the RAM sees no access while reset is held.
  always_comb begin
    w_cpu_elig  = 1'b0;
    w_cpu_win   = 1'b0;
    w_dbg_win   = 1'b0;
    w_state_nxt = ST_IDLE;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    dbg_gnt     = 1'b0;
    cpu_stall   = 1'b0;

    if (reset_n) begin
      w_cpu_elig = (cpu_read || cpu_write) && (r_state != ST_CPU_RSP);
      w_dbg_win  = dbg_req && (!w_cpu_elig || w_force);
      w_cpu_win  = w_cpu_elig && !w_dbg_win;

      if (w_dbg_win) begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        dbg_gnt   = 1'b1;
        if (!dbg_we) begin
          w_state_nxt = ST_DBG_RSP;
        end
      end else if (w_cpu_win) begin
        mem_en    = 1'b1;
        mem_we    = cpu_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!cpu_write) begin
          w_state_nxt = ST_CPU_RSP;
        end
      end

      cpu_stall = w_cpu_elig && !(w_cpu_win && cpu_write);
    end
  end

  assign dbg_rvalid = (r_state == ST_DBG_RSP);
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = (r_state == ST_CPU_RSP) ? mem_rdata : '0;

endmodule
